// File: rtl/heading_display_pkg.sv
// Shared constants for the heading display: seven-segment glyphs (active low,
// bit order {g,f,e,d,c,b,a}), compass sector bounds and the conversion FSM encoding.
package heading_display_pkg;

  localparam int BIN_W = 9;
  localparam int BCD_W = 12;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_N     = 7'h48;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_W     = 7'h41;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DEG   = 7'h1C;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Inclusive lower bounds of each compass sector, plus the first invalid heading.
  localparam logic [8:0] SEC_NE      = 9'd23;
  localparam logic [8:0] SEC_E       = 9'd68;
  localparam logic [8:0] SEC_SE      = 9'd113;
  localparam logic [8:0] SEC_S       = 9'd158;
  localparam logic [8:0] SEC_SW      = 9'd203;
  localparam logic [8:0] SEC_W       = 9'd248;
  localparam logic [8:0] SEC_NW      = 9'd293;
  localparam logic [8:0] SEC_N_HI    = 9'd338;
  localparam logic [8:0] HEADING_MAX = 9'd360;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock after start.
// done is high during the final iteration; bcd holds the result from the next cycle.
module bin2bcd_seq
  import heading_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

  logic [BCD_W+BIN_W-1:0] sh_q, sh_d;
  logic [3:0]             cnt_q;
  logic                   run_q;

  // NOTE: combinational blocks assign a default to every output first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (sh_d[BIN_W+4*i +: 4] >= 4'd5) begin
        sh_d[BIN_W+4*i +: 4] = sh_d[BIN_W+4*i +: 4] + 4'd3;
      end
    end
    sh_d = sh_d << 1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= {{BCD_W{1'b0}}, bin};
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == ITER_LAST) run_q <= 1'b0;
    end
  end

  assign done = run_q && (cnt_q == ITER_LAST);
  assign bcd  = sh_q[BIN_W +: BCD_W];

endmodule

// File: rtl/heading_display.sv
// Heading-to-seven-segment stage: queues one pending heading, converts it to BCD,
// commits digits plus compass label, and scans the 8-digit multiplexed display.
module heading_display
  import heading_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] heading,
  input  logic       heading_valid,
  input  logic       mag_error,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an,
  output logic       busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  conv_state_e state_q, state_d;
  logic [8:0]  value_q, pend_val_q;
  logic        pend_q;
  logic        conv_start, conv_done, in_range;
  logic [11:0] conv_bcd;
  logic [7:0][6:0] disp_q, disp_d;
  logic [6:0]  dir_hi, dir_lo, glyph;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  an_q;
  logic [6:0]  seg_q;

  assign in_range = (value_q < HEADING_MAX);

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE:   if (heading_valid || pend_q) state_d = ST_LOAD;
      ST_LOAD: begin
        conv_start = in_range;
        state_d    = in_range ? ST_SHIFT : ST_COMMIT;
      end
      ST_SHIFT:  if (conv_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A fresh valid in IDLE beats an older pending value; while busy, last write wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q    <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (heading_valid || pend_q) begin
        value_q <= heading_valid ? heading : pend_val_q;
        pend_q  <= 1'b0;
      end
    end else if (heading_valid) begin
      pend_val_q <= heading;
      pend_q     <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (value_q),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    dir_hi = SEG_BLANK;
    dir_lo = SEG_N;
    if (value_q < SEC_NE) begin
      dir_lo = SEG_N;
    end else if (value_q < SEC_E) begin
      dir_hi = SEG_N; dir_lo = SEG_E;
    end else if (value_q < SEC_SE) begin
      dir_lo = SEG_E;
    end else if (value_q < SEC_S) begin
      dir_hi = SEG_S; dir_lo = SEG_E;
    end else if (value_q < SEC_SW) begin
      dir_lo = SEG_S;
    end else if (value_q < SEC_W) begin
      dir_hi = SEG_S; dir_lo = SEG_W;
    end else if (value_q < SEC_NW) begin
      dir_lo = SEG_W;
    end else if (value_q < SEC_N_HI) begin
      dir_hi = SEG_N; dir_lo = SEG_W;
    end
  end

  always_comb begin
    disp_d    = '1;
    disp_d[3] = SEG_DEG;
    if (in_range) begin
      disp_d[0] = digit_glyph(conv_bcd[3:0]);
      disp_d[1] = (BLANK_LEADING && conv_bcd[11:4] == 8'd0) ? SEG_BLANK
                                                             : digit_glyph(conv_bcd[7:4]);
      disp_d[2] = (BLANK_LEADING && conv_bcd[11:8] == 4'd0) ? SEG_BLANK
                                                             : digit_glyph(conv_bcd[11:8]);
      disp_d[4] = dir_lo;
      disp_d[5] = dir_hi;
    end else begin
      disp_d[2:0] = {SEG_DASH, SEG_DASH, SEG_DASH};
    end
  end

  // NOTE: the display registers are reset explicitly so a blank panel is
  // guaranteed after reset instead of whatever the flops power up with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        disp_q <= '1;
    else if (state_q == ST_COMMIT)    disp_q <= disp_d;
  end

  // Sensor error overrides the numeric and direction fields without touching disp_q.
  always_comb begin
    glyph = disp_q[idx_q];
    if (mag_error) begin
      case (idx_q)
        3'd0, 3'd1: glyph = SEG_R;
        3'd2:       glyph = SEG_E;
        3'd4, 3'd5: glyph = SEG_BLANK;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      an_q  <= ~(8'b1 << idx_q);
      seg_q <= glyph;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_heading_display.sv
// Randomised and directed bench for heading_display; expected frames come from
// a decimal/sector arithmetic model of the committed heading.
`timescale 1ns/1ps
module tb_heading_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] heading = '0;
  logic       heading_valid = 1'b0;
  logic       mag_error = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int last_h = 0;
  bit have = 1'b0;

  always #5 clk = ~clk;

  heading_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .heading       (heading),
    .heading_valid (heading_valid),
    .mag_error     (mag_error),
    .seg           (seg),
    .dp            (dp),
    .an            (an),
    .busy          (busy)
  );

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_DEG   = 7'h1C;
  localparam logic [6:0] G_N     = 7'h48;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_W     = 7'h41;
  localparam logic [6:0] G_R     = 7'h2F;
  logic [6:0] dig_g [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected 8-digit frame, digit 0 in the low 7 bits.
  function automatic logic [55:0] model_frame(input int h, input bit committed, input bit err);
    logic [7:0][6:0] f;
    int hund, tens, ones;
    f = '1;
    if (committed) begin
      f[3] = G_DEG;
      if (h >= 360) begin
        f[2:0] = {G_DASH, G_DASH, G_DASH};
      end else begin
        hund = h / 100;
        tens = (h / 10) % 10;
        ones = h % 10;
        f[0] = dig_g[ones];
        f[1] = (hund == 0 && tens == 0) ? G_BLANK : dig_g[tens];
        f[2] = (hund == 0) ? G_BLANK : dig_g[hund];
        case (((h + 22) / 45) % 8)
          0: f[4] = G_N;
          1: begin f[5] = G_N; f[4] = G_E; end
          2: f[4] = G_E;
          3: begin f[5] = G_S; f[4] = G_E; end
          4: f[4] = G_S;
          5: begin f[5] = G_S; f[4] = G_W; end
          6: f[4] = G_W;
          default: begin f[5] = G_N; f[4] = G_W; end
        endcase
      end
    end
    if (err) begin
      f[2] = G_E; f[1] = G_R; f[0] = G_R;
      f[5] = G_BLANK; f[4] = G_BLANK;
    end
    return f;
  endfunction

  task automatic read_frame(output logic [55:0] frame);
    logic [7:0][6:0] f;
    logic [7:0] seen;
    f = '1;
    seen = '0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 8 * DIV + 4 && seen != 8'hFF; c++) begin
      for (int d = 0; d < 8; d++) begin
        if (an == ~(8'h01 << d)) begin
          f[d] = seg;
          seen[d] = 1'b1;
        end
      end
      @(negedge clk);
    end
    check("scan_cover", seen, 8'hFF);
    frame = f;
  endtask

  task automatic expect_frame(input string tag, input int h, input bit committed, input bit err);
    logic [55:0] fr;
    read_frame(fr);
    check(tag, fr, model_frame(h, committed, err));
  endtask

  task automatic send(input int h);
    @(negedge clk);
    heading = 9'(h);
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic run_one(input int h);
    send(h);
    check($sformatf("busy_on_%0d", h), busy, 1'b1);
    wait_idle();
    last_h = h;
    have = 1'b1;
    expect_frame($sformatf("frame_%0d", h), h, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, busy=%0b", busy);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dir_list[12] = '{22, 23, 337, 338, 359, 0, 5, 60, 100, 105, 360, 511};

    // Reset and scan timing
    repeat (5) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_busy", busy, 1'b0);
    check("rst_dp", dp, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("scan_first", an, 8'hFE);
    repeat (DIV) @(negedge clk);
    check("scan_second", an, 8'hFD);
    repeat (7 * DIV) @(negedge clk);
    check("scan_wrap", an, 8'hFE);
    expect_frame("reset_blank", 0, 1'b0, 1'b0);

    // First conversion: busy length and 45 degrees NE
    send(45);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("busy_len", n, 11);
    last_h = 45;
    have = 1'b1;
    expect_frame("frame_45", 45, 1'b1, 1'b0);

    foreach (dir_list[i]) run_one(dir_list[i]);

    // Back-to-back valids: 200 is overwritten by 300 while 100 converts
    begin
      logic [7:0][6:0] cur;
      int q[$];
      bit pb;
      int rises;
      cur = model_frame(last_h, have, 1'b0);
      q = '{100, 300};
      pb = busy;
      rises = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        for (int d = 0; d < 8; d++)
          if (an == ~(8'h01 << d)) check($sformatf("b2b_seg_k%0d", k), seg, cur[d]);
        if (busy && !pb) rises++;
        if (!busy && pb && q.size() > 0) cur = model_frame(q.pop_front(), 1'b1, 1'b0);
        pb = busy;
        case (k)
          0: begin heading = 9'd100; heading_valid = 1'b1; end
          3: begin heading = 9'd200; heading_valid = 1'b1; end
          5: begin heading = 9'd300; heading_valid = 1'b1; end
          default: heading_valid = 1'b0;
        endcase
      end
      check("b2b_conversions", rises, 2);
      check("b2b_commits_left", q.size(), 0);
      last_h = 300;
    end
    expect_frame("b2b_final", 300, 1'b1, 1'b0);

    // Valid arriving during COMMIT is kept as pending and processed next
    send(10);
    repeat (10) @(negedge clk);
    heading = 9'd20;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
    @(negedge clk);
    check("commit_coincident_reload", busy, 1'b1);
    wait_idle();
    last_h = 20;
    expect_frame("commit_coincident_frame", 20, 1'b1, 1'b0);

    // Out of range, then sensor error override and background conversion
    run_one(400);
    mag_error = 1'b1;
    expect_frame("err_over_dash", 400, 1'b1, 1'b1);
    mag_error = 1'b0;
    expect_frame("dash_restored", 400, 1'b1, 1'b0);
    mag_error = 1'b1;
    send(123);
    wait_idle();
    expect_frame("err_background", 123, 1'b1, 1'b1);
    mag_error = 1'b0;
    last_h = 123;
    expect_frame("background_result", 123, 1'b1, 1'b0);

    // Randomised headings with occasional sensor error
    for (int i = 0; i < 16; i++) begin
      run_one(int'($urandom_range(0, 511)));
      if ($urandom_range(0, 3) == 0) begin
        mag_error = 1'b1;
        expect_frame($sformatf("rand_err_%0d", last_h), last_h, 1'b1, 1'b1);
        mag_error = 1'b0;
      end
    end

    // Reset during the fifth SHIFT cycle aborts without committing
    send(250);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_an", an, 8'hFF);
    check("abort_seg", seg, 7'h7F);
    check("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    have = 1'b0;
    expect_frame("abort_blank", 0, 1'b0, 1'b0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("abort_no_resume", n, 0);
    expect_frame("abort_still_blank", 0, 1'b0, 1'b0);
    run_one(77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/heading_display.md
Name: heading_display

Overview:
- Downstream consumer of the compass heading stage.
- Takes the registered 9-bit heading (0-359) and its valid pulse, and converts the value to BCD with a sequential double-dabble.
- Derives an 8-point direction label and drives the Nexys A7 8-digit multiplexed seven-segment display.
- Sits between the heading calculation stage and the board top-level segment/anode pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays enabled (1 kHz per digit at 100 MHz).
- BLANK_LEADING, 1, 1 = blank leading zeros in the numeric field; 0 = show them.

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- heading  in  9  heading in degrees, nominal 0-359
- heading_valid  in  1  one-cycle pulse: heading is new
- mag_error  in  1  level: sensor I2C error
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low, always 1 (off)
- an  out  8  digit anodes, active low, one-hot
- busy  out  1  conversion in progress

Behaviour:
- Reset values: seg=7'h7F, dp=1, an=8'hFF, busy=0, all digit registers blank, scan index=0, refresh counter=0, pending flag=0.
- Asserting reset mid-conversion aborts the conversion. No partial result is ever committed.
- Conversion FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE -> LOAD on heading_valid, or when the pending flag is set.
  - LOAD latches the value (one cycle); busy=1 from LOAD until the cycle after COMMIT.
  - SHIFT runs exactly 9 iterations of add-3-if->=5 then shift-left, over 12 BCD bits.
  - COMMIT writes the display registers (one cycle), then returns to IDLE.
  - Latency from the valid pulse to updated display registers is 11 cycles.
- heading_valid while busy=1: the value is captured into a pending register (last write wins) and the pending flag is set. After COMMIT, the FSM goes to LOAD with the pending value and clears the flag.
- Simultaneous valid and COMMIT: the new value goes to pending and is processed next.
- Out-of-range input (heading >= 360): skip SHIFT and commit "---" (three '-' digits) with a blank direction field.
- mag_error=1 has priority over all heading data:
  - Digits 2..0 show 'E','r','r' and direction digits 5..4 are blank.
  - The FSM keeps converting in the background.
  - The display reverts to the last committed heading once mag_error=0.
- Digit map (index 0 = rightmost):
  - 0 = ones, 1 = tens, 2 = hundreds.
  - 3 = degree symbol (a,b,f,g on -> 7'h1C).
  - 4 = second direction letter, 5 = first direction letter.
  - 6 and 7 are blank.
- Leading-zero blanking (BLANK_LEADING=1): hundreds is blank if 0; tens is blank if hundreds=0 and tens=0; ones is always shown.
- Direction sectors, on the committed heading, using inclusive lower bounds:
  - 0-22 N, 23-67 NE, 68-112 E, 113-157 SE, 158-202 S, 203-247 SW, 248-292 W, 293-337 NW, 338-359 N.
  - Single-letter labels sit in digit 4; digit 5 is then blank.
- Letter glyphs: N=7'h48 (a,b,c,e,f), E=7'h06, S=7'h12, W=7'h41 (b,c,d,e,f), r=7'h2F.
- Digit glyphs: '0'=7'h40, '1'=7'h79, '-'=7'h3F, blank=7'h7F.
- Scan behaviour:
  - The refresh counter counts 0..REFRESH_DIV-1; at wrap the scan index increments mod 8.
  - an = ~(1<<index), registered. seg is registered on the same cycle as an, so there is no ghosting skew.
  - First cycle after reset deasserts: an=8'hFE.

Decomposition:
- Package heading_display_pkg holds:
  - segment glyph constants (digits 0-9, N/E/S/W/r/-/degree/blank);
  - sector boundary constants 23/68/113/158/203/248/293/338;
  - FSM state encoding.
- Sub-module bin2bcd_seq: sequential 9-bit to 3-digit BCD converter.
  - Ports: clk, reset, start, bin[8:0], done, bcd[11:0].
  - It owns the SHIFT iteration counter.
- The top level owns the pending logic, sector decode, glyph mux and scan.

Test Plan:
- Reset: hold reset for 5 cycles -> an=8'hFF, seg=7'h7F, busy=0. After release: an=8'hFE on the first cycle and 8'hFD after REFRESH_DIV cycles; wraps to 8'hFE after 8*REFRESH_DIV cycles.
- heading=45 pulse -> busy high for 11 cycles. Then digits 2..0 = blank,'4','5' (7'h7F,7'h19,7'h12), digit 3 = 7'h1C, digits 5..4 = N,E.
- Sector edges:
  - 22 -> "22" N.
  - 23 -> "23" NE.
  - 337 -> "337" NW.
  - 338 -> "338" N.
  - 359 -> "359" N.
  - 0 -> ones '0' only, N.
- Back-to-back valids: 100 at t0, 200 at t0+3, 300 at t0+5 -> first commit shows 100; pending holds 300 (200 overwritten); second commit shows 300; no third conversion.
- heading=400 -> digits 2..0 '-','-','-', direction blank. Then mag_error=1 -> 'E','r','r'. Then mag_error=0 -> the display returns to "---".
- Assert reset at cycle 5 of SHIFT while converting 250 -> all outputs return to reset values. After release the display stays blank until the next valid.
